cmac_pipe: RTL and testbench

//  Pipelined, parametrised complex multiply / multiply-accumulate on sign-magnitude Qm.n data.

---
 rtl/cmac_pkg.sv | 39 +++
 rtl/cmac_pipe_prod.sv | 32 +++
 rtl/cmac_pipe.sv | 161 ++++++++++++++++
 tb/tb_cmac_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_pkg.sv
// Shared widths and number-format helpers for the complex multiply/accumulate pipe.
package cmac_pkg;

    localparam int N = 16;              // sign-magnitude word width (sign at N-1)
    localparam int Q = 15;              // fractional bits
    localparam int G = 4;               // accumulator guard bits
    localparam int W = N + G + 1;       // internal two's-complement width

    localparam logic [N-2:0] MAX_MAG = {(N-1){1'b1}};

    // Sign-magnitude (N bits) to two's complement (W bits); -0 maps to 0.
    function automatic logic [W-1:0] sm2tc(input logic [N-1:0] sm);
        logic [W-1:0] mag;
        mag = {{(W-N+1){1'b0}}, sm[N-2:0]};
        if (sm[N-1]) begin
            sm2tc = {W{1'b0}} - mag;
        end else begin
            sm2tc = mag;
        end
    endfunction

    // Two's complement (W bits) to saturated sign-magnitude (N bits); ovr set on clamp.
    function automatic logic [N-1:0] tc2sm_sat(input logic [W-1:0] tc, output logic ovr);
        logic [W-1:0] mag;
        if (tc[W-1]) begin
            mag = {W{1'b0}} - tc;
        end else begin
            mag = tc;
        end
        if (mag > {{(W-N+1){1'b0}}, MAX_MAG}) begin
            ovr       = 1'b1;
            tc2sm_sat = {tc[W-1], MAX_MAG};
        end else begin
            ovr       = 1'b0;
            tc2sm_sat = {tc[W-1] & (|mag), mag[N-2:0]};
        end
    endfunction

endpackage

// File: rtl/cmac_pipe_prod.sv
// One combinational sign-magnitude fixed-point product with magnitude clamp.
module cmul_prod_sm #(
    parameter int N = 16,
    parameter int Q = 15
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] p,
    output logic         ovr
);

    localparam logic [2*N-3:0] MAG_LIMIT = {{(N-1){1'b0}}, {(N-1){1'b1}}};

    logic [2*N-3:0] prod_s;
    logic [2*N-3:0] shifted_s;
    logic [N-2:0]   mag_s;

    // Magnitude multiply, truncating shift, clamp, and sign with -0 suppressed.
    always_comb begin
        prod_s    = {{(N-1){1'b0}}, x[N-2:0]} * {{(N-1){1'b0}}, y[N-2:0]};
        shifted_s = prod_s >> Q;
        if (shifted_s > MAG_LIMIT) begin
            mag_s = {(N-1){1'b1}};
            ovr   = 1'b1;
        end else begin
            mag_s = shifted_s[N-2:0];
            ovr   = 1'b0;
        end
        p = {(x[N-1] ^ y[N-1]) & (|mag_s), mag_s};
    end

endmodule

// File: rtl/cmac_pipe.sv
// Three-stage complex multiply / multiply-accumulate with valid/ready and saturation.
module cmac_pipe
    import cmac_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    input  logic [N-1:0] i_d,
    input  logic         i_acc,
    input  logic         i_last,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_re,
    output logic [N-1:0] o_im,
    output logic         o_ovr,
    output logic         o_ovr_sticky,
    input  logic         i_clr
);

    logic         adv_s;
    logic [N-1:0] ac_s, bd_s, ad_s, bc_s;
    logic         ac_ovr_s, bd_ovr_s, ad_ovr_s, bc_ovr_s;

    logic         p_valid_r, p_ovr_r, p_acc_r, p_last_r;
    logic [W-1:0] p_ac_r, p_bd_r, p_ad_r, p_bc_r;

    logic         s_valid_r, s_ovr_r, s_acc_r, s_last_r;
    logic [W-1:0] s_re_r, s_im_r;

    logic [W-1:0] acc_re_r, acc_im_r;
    logic         acc_ovr_r;

    logic [W-1:0] sum_re_s, sum_im_s, res_re_s, res_im_s;
    logic         sum_ovr_s, res_ovr_s, sat_re_s, sat_im_s;
    logic [N-1:0] sm_re_s, sm_im_s;
    logic         emit_s, ovr_out_s, acc_wr_s, sticky_next_s;

    // The whole pipe moves together whenever the output register can take a new value.
    assign adv_s   = ~o_valid | i_ready;
    assign o_ready = adv_s;

    cmul_prod_sm #(.N(N), .Q(Q)) u_ac (.x(i_a), .y(i_c), .p(ac_s), .ovr(ac_ovr_s));
    cmul_prod_sm #(.N(N), .Q(Q)) u_bd (.x(i_b), .y(i_d), .p(bd_s), .ovr(bd_ovr_s));
    cmul_prod_sm #(.N(N), .Q(Q)) u_ad (.x(i_a), .y(i_d), .p(ad_s), .ovr(ad_ovr_s));
    cmul_prod_sm #(.N(N), .Q(Q)) u_bc (.x(i_b), .y(i_c), .p(bc_s), .ovr(bc_ovr_s));

    // Stage P: register the four products in two's complement with their clamp flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_r <= 1'b0;
            p_ovr_r   <= 1'b0;
            p_acc_r   <= 1'b0;
            p_last_r  <= 1'b0;
            p_ac_r    <= {W{1'b0}};
            p_bd_r    <= {W{1'b0}};
            p_ad_r    <= {W{1'b0}};
            p_bc_r    <= {W{1'b0}};
        end else if (adv_s) begin
            p_valid_r <= i_valid;
            p_ovr_r   <= ac_ovr_s | bd_ovr_s | ad_ovr_s | bc_ovr_s;
            p_acc_r   <= i_acc;
            p_last_r  <= i_acc & i_last;
            p_ac_r    <= sm2tc(ac_s);
            p_bd_r    <= sm2tc(bd_s);
            p_ad_r    <= sm2tc(ad_s);
            p_bc_r    <= sm2tc(bc_s);
        end
    end

    // Stage S: exact complex sum/difference in the wide format.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_r <= 1'b0;
            s_ovr_r   <= 1'b0;
            s_acc_r   <= 1'b0;
            s_last_r  <= 1'b0;
            s_re_r    <= {W{1'b0}};
            s_im_r    <= {W{1'b0}};
        end else if (adv_s) begin
            s_valid_r <= p_valid_r;
            s_ovr_r   <= p_ovr_r;
            s_acc_r   <= p_acc_r;
            s_last_r  <= p_last_r;
            s_re_r    <= p_ac_r - p_bd_r;
            s_im_r    <= p_ad_r + p_bc_r;
        end
    end

    // Stage A: pick plain or accumulated result; a same-cycle clear empties the accumulator first.
    always_comb begin
        sum_re_s  = (i_clr ? {W{1'b0}} : acc_re_r) + s_re_r;
        sum_im_s  = (i_clr ? {W{1'b0}} : acc_im_r) + s_im_r;
        sum_ovr_s = (i_clr ? 1'b0 : acc_ovr_r) | s_ovr_r;
        if (s_acc_r) begin
            res_re_s  = sum_re_s;
            res_im_s  = sum_im_s;
            res_ovr_s = sum_ovr_s;
        end else begin
            res_re_s  = s_re_r;
            res_im_s  = s_im_r;
            res_ovr_s = s_ovr_r;
        end
        sat_re_s      = 1'b0;
        sat_im_s      = 1'b0;
        sm_re_s       = tc2sm_sat(res_re_s, sat_re_s);
        sm_im_s       = tc2sm_sat(res_im_s, sat_im_s);
        ovr_out_s     = res_ovr_s | sat_re_s | sat_im_s;
        emit_s        = s_valid_r & (~s_acc_r | s_last_r);
        acc_wr_s      = adv_s & s_valid_r & s_acc_r;
        sticky_next_s = (i_clr ? 1'b0 : o_ovr_sticky) | (adv_s & emit_s & ovr_out_s);
    end

    // Accumulator: load running sum on open-frame beats, empty on frame end or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_re_r  <= {W{1'b0}};
            acc_im_r  <= {W{1'b0}};
            acc_ovr_r <= 1'b0;
        end else if (acc_wr_s) begin
            if (s_last_r) begin
                acc_re_r  <= {W{1'b0}};
                acc_im_r  <= {W{1'b0}};
                acc_ovr_r <= 1'b0;
            end else begin
                acc_re_r  <= sum_re_s;
                acc_im_r  <= sum_im_s;
                acc_ovr_r <= sum_ovr_s;
            end
        end else if (i_clr) begin
            acc_re_r  <= {W{1'b0}};
            acc_im_r  <= {W{1'b0}};
            acc_ovr_r <= 1'b0;
        end
    end

    // Output register: hold result until taken; sticky flag collects every flagged result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid      <= 1'b0;
            o_re         <= {N{1'b0}};
            o_im         <= {N{1'b0}};
            o_ovr        <= 1'b0;
            o_ovr_sticky <= 1'b0;
        end else begin
            o_ovr_sticky <= sticky_next_s;
            if (adv_s) begin
                o_valid <= emit_s;
                if (emit_s) begin
                    o_re  <= sm_re_s;
                    o_im  <= sm_im_s;
                    o_ovr <= ovr_out_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmac_pipe.sv
// Self-checking bench for cmac_pipe: vector table plus scoreboard and corner-case sequences.
module tb_cmac_pipe;

    logic        clk = 1'b0;
    logic        rst_n, i_valid, o_ready, i_acc, i_last, o_valid, i_ready;
    logic        o_ovr, o_ovr_sticky, i_clr;
    logic [15:0] i_a, i_b, i_c, i_d, o_re, o_im;

    cmac_pipe dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d), .i_acc(i_acc), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_re(o_re), .o_im(o_im),
        .o_ovr(o_ovr), .o_ovr_sticky(o_ovr_sticky), .i_clr(i_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b, c, d;
        logic        acc, last;
        logic [15:0] re, im;
        logic        ovr;
        bit          emits;
    } vec_t;

    typedef struct {
        logic [15:0] re, im;
        logic        ovr;
        int          acc_cyc;
        bit          lat_chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, b, c, d, input logic acc, last,
                                input logic [15:0] re, im, input logic ovr, input bit emits);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.d = d; v.acc = acc; v.last = last;
        v.re = re; v.im = im; v.ovr = ovr; v.emits = emits;
        return v;
    endfunction

    // Drive one beat (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic send_beat(input vec_t v, input bit lat_chk);
        int   budget = 0;
        bit   done   = 1'b0;
        exp_t e;
        i_valid = 1'b1; i_a = v.a; i_b = v.b; i_c = v.c; i_d = v.d;
        i_acc = v.acc; i_last = v.last;
        while (!done) begin
            @(negedge clk);
            if (o_ready) begin
                done = 1'b1;
                if (v.emits) begin
                    e.re = v.re; e.im = v.im; e.ovr = v.ovr;
                    e.acc_cyc = cyc; e.lat_chk = lat_chk;
                    sb_q.push_back(e);
                end
            end
            @(posedge clk); #1;
            budget++;
            if (!done && budget > 200) begin
                check("accept_timeout", 32'd1, 32'd0);
                done = 1'b1;
            end
        end
        i_valid = 1'b0; i_acc = 1'b0; i_last = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been seen.
    task automatic drain();
        int budget = 0;
        while (sb_q.size() != 0 && budget < 60) begin
            @(posedge clk); #1;
            budget++;
        end
        check("drain_left", sb_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // Cycle counter for latency measurement.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pop/compare on handshake, check held outputs stay stable while stalled.
    initial begin
        bit          hold = 1'b0;
        logic [15:0] h_re, h_im;
        logic        h_ovr;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", o_valid, 1'b1);
                    check("hold_data", {o_re, o_im, 15'd0, o_ovr}, {h_re, h_im, 15'd0, h_ovr});
                end
                if (o_valid && i_ready) begin
                    n_out++;
                    hold = 1'b0;
                    if (sb_q.size() == 0) begin
                        check("unexpected_output", {o_re, o_im}, 32'd0);
                        n_fail++;
                    end else begin
                        e = sb_q.pop_front();
                        check("o_re", o_re, e.re);
                        check("o_im", o_im, e.im);
                        check("o_ovr", o_ovr, e.ovr);
                        if (e.lat_chk) check("latency", cyc - e.acc_cyc, 32'd3);
                    end
                end else if (o_valid) begin
                    hold = 1'b1; h_re = o_re; h_im = o_im; h_ovr = o_ovr;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[19];
    vec_t hv;
    int   out_before;

    initial begin
        // plain products: a, b, c, d, acc, last, re, im, ovr, emits
        tbl[0]  = mk(16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0, 1'b1);
        tbl[1]  = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b1);
        tbl[2]  = mk(16'h8000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tbl[3]  = mk(16'hC000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 16'hA000, 16'h0000, 1'b0, 1'b1);
        tbl[4]  = mk(16'h4000, 16'h2000, 16'h2000, 16'h4000, 1'b0, 1'b0, 16'h0000, 16'h2800, 1'b0, 1'b1);
        tbl[5]  = mk(16'h0001, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tbl[6]  = mk(16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        tbl[7]  = mk(16'h8003, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b0, 1'b1);
        tbl[8]  = mk(16'h3000, 16'h5000, 16'h2000, 16'h6000, 1'b0, 1'b0, 16'hB000, 16'h3800, 1'b0, 1'b1);
        // 3-beat frame of 0.25 each
        tbl[9]  = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[10] = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[11] = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b1, 16'h6000, 16'h0000, 1'b0, 1'b1);
        // 4-beat frame saturates
        tbl[12] = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[13] = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[14] = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[15] = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b1);
        // plain beat inside an open frame passes through untouched
        tbl[16] = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[17] = mk(16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0, 1'b1, 16'h4000, 16'h0000, 1'b0, 1'b1);
        tbl[18] = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b1, 16'h4000, 16'h0000, 1'b0, 1'b1);

        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b0;
        i_a = 16'h0000; i_b = 16'h0000; i_c = 16'h0000; i_d = 16'h0000;
        i_acc = 1'b0; i_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_re", o_re, 16'h0000);
        check("rst_o_im", o_im, 16'h0000);
        check("rst_o_ovr", o_ovr, 1'b0);
        check("rst_sticky", o_ovr_sticky, 1'b0);
        check("rst_o_ready", o_ready, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) send_beat(tbl[i], 1'b1);
        drain();

        // sticky flag persists, clear drops it and empties the accumulator
        @(negedge clk);
        check("sticky_set", o_ovr_sticky, 1'b1);
        @(posedge clk); #1;
        hv = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        send_beat(hv, 1'b1);
        send_beat(hv, 1'b1);
        repeat (5) @(posedge clk);
        #1 i_clr = 1'b1;
        @(posedge clk);
        #1 i_clr = 1'b0;
        @(negedge clk);
        check("sticky_clr", o_ovr_sticky, 1'b0);
        @(posedge clk); #1;
        hv = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b1, 16'h2000, 16'h0000, 1'b0, 1'b1);
        send_beat(hv, 1'b1);
        drain();

        // backpressure: 8 streamed beats with a 5-cycle downstream stall
        out_before = n_out;
        fork
            begin
                for (int k = 1; k <= 8; k++) begin
                    hv = mk(16'(k * 16'h0800), 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0,
                            16'(k * 16'h0400), 16'h0000, 1'b0, 1'b1);
                    send_beat(hv, 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out - out_before, 32'd8);

        // asynchronous reset mid-frame while a saturated result is held
        hv = mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        send_beat(hv, 1'b1);
        send_beat(hv, 1'b1);
        send_beat(tbl[1], 1'b0);
        i_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_valid", o_valid, 1'b1);
        check("pre_rst_sticky", o_ovr_sticky, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_o_valid", o_valid, 1'b0);
        check("arst_o_re", o_re, 16'h0000);
        check("arst_o_im", o_im, 16'h0000);
        check("arst_o_ovr", o_ovr, 1'b0);
        check("arst_sticky", o_ovr_sticky, 1'b0);
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        send_beat(tbl[9], 1'b1);
        send_beat(tbl[10], 1'b1);
        send_beat(tbl[11], 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
